// File: rtl/mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a hold limit.
// Optional MUX4_ARB_LOCK_EN adds a LOCK input that suppresses hold-limit preemption.
module mux4_arbiter #(
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic                 lock,
`endif
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic                 busy,
  output logic                 handover,
  output logic [CNT_WIDTH-1:0] hold_cnt
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               state, state_nxt;
  logic [1:0]           last, last_nxt;
  logic [3:0]           gnt_nxt;
  logic [1:0]           sel_nxt;
  logic                 busy_nxt, handover_nxt;
  logic [CNT_WIDTH-1:0] hold_nxt;
  logic [3:0]           owner_oh, cand;
  logic [2:0]           pick;
  logic                 at_max, lock_act;

  // Returns {found, index} of the first set bit searching ptr+1, ptr+2, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] ptr);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!r[2] && c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c >= CNT_WIDTH'(MAX_HOLD)) ? c : c + CNT_WIDTH'(1);
  endfunction

`ifdef MUX4_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // The owner never competes against itself, so its bit is masked out while OWNED.
  assign owner_oh = 4'b0001 << sel;
  assign cand     = (state == OWNED) ? (req & ~owner_oh) : req;
  assign pick     = rr_pick(cand, last);
  assign at_max   = (hold_cnt == CNT_WIDTH'(MAX_HOLD));

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    last_nxt     = last;
    hold_nxt     = hold_cnt;
    handover_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt = OWNED;
          gnt_nxt   = 4'b0001 << pick[1:0];
          sel_nxt   = pick[1:0];
          last_nxt  = pick[1:0];
          hold_nxt  = CNT_WIDTH'(1);
        end
      end
      OWNED: begin
        if ((!req[sel] || (at_max && !lock_act)) && pick[2]) begin
          // Release or preemption with someone waiting: hand over without a dead cycle.
          gnt_nxt      = 4'b0001 << pick[1:0];
          sel_nxt      = pick[1:0];
          last_nxt     = pick[1:0];
          hold_nxt     = CNT_WIDTH'(1);
          handover_nxt = 1'b1;
        end else if (!req[sel]) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          hold_nxt  = '0;
        end else begin
          hold_nxt  = sat_inc(hold_cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = |gnt_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      last     <= 2'd3;
      busy     <= 1'b0;
      handover <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      busy     <= busy_nxt;
      handover <= handover_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter (MAX_HOLD=4): directed REQ patterns, expected outputs queued per cycle.
module tb_mux4_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy, handover;
  logic [7:0] hold_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       ho;
    logic [7:0] h;
    logic       chk_h;
  } exp_t;

  exp_t q[$];

  mux4_arbiter #(.MAX_HOLD(MAXH), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
`ifdef MUX4_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .handover (handover),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  // Monitor: every edge with a queued expectation is compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("gnt", {4'b0, gnt}, {4'b0, e.g});
      check("sel", {6'b0, sel}, {6'b0, e.s});
      check("busy", {7'b0, busy}, {7'b0, |e.g});
      check("handover", {7'b0, handover}, {7'b0, e.ho});
      if (e.chk_h) check("hold_cnt", hold_cnt, e.h);
      check("onehot0", {7'b0, $onehot0(gnt)}, 8'd1);
    end
  end

  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                      input logic ho, input logic [7:0] h, input logic ch);
    exp_t e;
    @(negedge clk);
    req = r;
    e.g = g; e.s = s; e.ho = ho; e.h = h; e.chk_h = ch;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         o;
    logic [3:0] eg;
    logic [1:0] es;
    logic [7:0] eh;

    // Idle after reset.
    do_reset();
    repeat (5) step(4'b0000, 4'b0000, 2'd0, 1'b0, 8'd0, 1'b1);

    // Single requester 2; hold saturates at MAXH; release goes idle with SEL kept.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      eh = (k + 1 > MAXH) ? 8'(MAXH) : 8'(k + 1);
      step(4'b0100, 4'b0100, 2'd2, 1'b0, eh, 1'b1);
    end
    step(4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0, 1'b0);
    // Sole requester re-requests: granted again from IDLE, no handover.
    step(4'b0100, 4'b0100, 2'd2, 1'b0, 8'd1, 1'b1);
    step(4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0, 1'b0);

    // Full contention: rotation 0,1,2,3,0 every MAXH cycles.
    do_reset();
    for (int k = 0; k < 4 * MAXH + 1; k++) begin
      o  = (k / MAXH) % 4;
      eg = 4'(4'b0001 << o);
      es = 2'(o);
      eh = 8'(k % MAXH + 1);
      step(4'b1111, eg, es, (k > 0) && (k % MAXH == 0), eh, 1'b1);
    end

    // Owner 1 drops with 3 and 0 pending: 3 wins; then saturation preemption.
    do_reset();
    step(4'b0010, 4'b0010, 2'd1, 1'b0, 8'd1, 1'b1);
    step(4'b1011, 4'b0010, 2'd1, 1'b0, 8'd2, 1'b1);
    step(4'b1001, 4'b1000, 2'd3, 1'b1, 8'd1, 1'b1);
    step(4'b1001, 4'b1000, 2'd3, 1'b0, 8'd2, 1'b1);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 8'd1, 1'b1);
    step(4'b0001, 4'b0001, 2'd0, 1'b0, 8'd2, 1'b1);
    step(4'b0001, 4'b0001, 2'd0, 1'b0, 8'd3, 1'b1);
    step(4'b0001, 4'b0001, 2'd0, 1'b0, 8'd4, 1'b1);
    step(4'b0001, 4'b0001, 2'd0, 1'b0, 8'd4, 1'b1);
    step(4'b0101, 4'b0100, 2'd2, 1'b1, 8'd1, 1'b1);
    step(4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0, 1'b0);

    // Asynchronous reset while owner 2 holds; pointer returns to favour requester 0 side.
    do_reset();
    step(4'b0100, 4'b0100, 2'd2, 1'b0, 8'd1, 1'b1);
    step(4'b0100, 4'b0100, 2'd2, 1'b0, 8'd2, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_gnt", {4'b0, gnt}, 8'h00);
    check("async_busy", {7'b0, busy}, 8'h00);
    check("async_sel", {6'b0, sel}, 8'h00);
    check("async_hold", hold_cnt, 8'h00);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0110, 4'b0010, 2'd1, 1'b0, 8'd1, 1'b1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0, 8'd0, 1'b0);

`ifdef MUX4_ARB_LOCK_EN
    // Lock suppresses preemption; dropping lock hands over on the next edge.
    do_reset();
    @(negedge clk);
    lock = 1'b1;
    for (int k = 0; k < 8; k++) begin
      eh = (k + 1 > MAXH) ? 8'(MAXH) : 8'(k + 1);
      step(4'b0011, 4'b0001, 2'd0, 1'b0, eh, 1'b1);
    end
    @(negedge clk);
    lock = 1'b0;
    q.push_back('{g: 4'b0010, s: 2'd1, ho: 1'b1, h: 8'd1, chk_h: 1'b1});
    step(4'b0000, 4'b0000, 2'd1, 1'b0, 8'd0, 1'b0);
`endif

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
Name: mux4_arbiter

Overview:
- Round-robin arbiter that shares one mux4 datapath between four requesters.
- Drives the mux4 SEL input and returns a one-hot grant to each requester.
- Limits the time one owner can hold the datapath while others wait.
- Sits between the requesting units (ALU operand sources, load path, etc.) and the shared 4:1 mux feeding the common bus.

Parameters:
- MAX_HOLD, 16, max consecutive cycles an owner keeps the grant while another request is pending; legal range 1..255.
- CNT_WIDTH, 8, width of the hold counter; must hold MAX_HOLD.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  4  per-requester request; bit i = requester i; held high while the requester needs the datapath.
- GNT  output  4  one-hot (or zero) registered grant; bit i = requester i owns the mux.
- SEL  output  2  registered mux4 select; equals index of the current owner.
- BUSY  output  1  high while any GNT bit is set.
- HANDOVER  output  1  one-cycle pulse on the cycle GNT changes from one owner to a different owner.
- HOLD_CNT  output  CNT_WIDTH  cycles the current owner has held the grant, saturating at MAX_HOLD.

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (RST_N). Assertion clears state immediately, independent of CLK.
- Reset values: GNT=0, SEL=0, BUSY=0, HANDOVER=0, HOLD_CNT=0, state=IDLE, round-robin pointer LAST=3 (so requester 0 wins first).
- All outputs are registered; latency from REQ to GNT is 1 cycle.
- States: IDLE, OWNED.
- IDLE:
  - REQ==0: stay in IDLE.
  - REQ!=0: pick the first set bit searching LAST+1, LAST+2, ... mod 4.
  - Next edge: GNT=onehot(winner), SEL=winner, LAST=winner, HOLD_CNT=1, go to OWNED. HANDOVER=0.
- OWNED, owner o:
  - Release: REQ[o]==0.
    - If other requests are pending: grant the next requester (round-robin from o) on the same edge, with no dead cycle. HANDOVER=1, HOLD_CNT=1.
    - Otherwise: GNT=0, go to IDLE. SEL keeps o.
  - Preempt: REQ[o]==1, HOLD_CNT==MAX_HOLD, and any other REQ bit set. Rotate to the next requester as above, HANDOVER=1.
  - Continue: otherwise keep the grant; HOLD_CNT increments, saturating at MAX_HOLD.
  - With no competition the owner holds indefinitely; once saturated, a new competing request is served on the next edge.
- GNT is never multi-hot.
- SEL always equals the index of the set GNT bit when BUSY=1; when idle it holds the last owner.
- HANDOVER is 0 for IDLE->OWNED and OWNED->IDLE transitions; it is high only on owner-to-different-owner changes, one cycle per change.
- Sole requester re-requesting after release: goes through IDLE (one cycle GNT=0) before the new grant.
- REQ bits of non-owners may toggle freely; the arbiter samples them only at decision points.
- Reset mid-grant: GNT drops asynchronously. After release the first grant follows the reset pointer (requester 0 has priority).
- MAX_HOLD=1: rotation every cycle under full contention.

Optional Feature:
- Macro: MUX4_ARB_LOCK_EN.
- Defined:
  - Adds input LOCK (1 bit).
  - While the owner holds REQ[o]=1 and LOCK=1, preemption is suppressed; HOLD_CNT still saturates.
  - Release by dropping REQ[o] works as normal.
  - LOCK is ignored in IDLE.
- Not defined: no LOCK port; preemption follows MAX_HOLD only.

Test Plan:
- Reset then REQ=4'b0000 for 5 cycles -> GNT=0, SEL=0, BUSY=0, HOLD_CNT=0 throughout.
- REQ=4'b0100 at cycle 0, dropped at cycle 6 -> GNT=4'b0100 and SEL=2 from cycle 1; HOLD_CNT counts 1..6; GNT=0 at cycle 7; HANDOVER never pulses.
- REQ=4'b1111 held, MAX_HOLD=4 -> grants rotate 0,1,2,3,0 every 4 cycles; each rotation has a one-cycle HANDOVER pulse; GNT always one-hot; SEL matches GNT.
- Owner 1 drops REQ while REQ[3] and REQ[0] are pending -> next edge GNT=4'b1000, SEL=3, HANDOVER=1, HOLD_CNT=1 (3 is chosen over 0 by round-robin).
- Owner 2 holds grant, RST_N pulsed low mid-cycle -> GNT=0 immediately, without a clock edge. After release with REQ=4'b0110, the first grant goes to requester 1.
- With MUX4_ARB_LOCK_EN, REQ=4'b0011, MAX_HOLD=2, LOCK=1 for 10 cycles -> requester 0 keeps grant and HOLD_CNT saturates at 2. After LOCK=0 -> next edge GNT=4'b0010, HANDOVER=1.
